// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive byte assembler.
// The receive FIFO is included only when UART_RX_FIFO_EN is defined.
package uart_rx_pkg;

    // Data bits per frame, sent LSB first.
    localparam int DATA_BITS = 8;

    // bit_idx value meaning "idle / stop-bit midpoint".
    localparam logic [3:0] IDX_IDLE = 4'd0;

    // bit_idx value of the last data bit; the next step to IDX_IDLE is the stop bit.
    localparam logic [3:0] IDX_LAST = 4'(DATA_BITS);

    // Frame assembler states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO for the UART byte assembler.
// It is used only when UART_RX_FIFO_EN is defined. DEPTH must be a power of two (>= 2).
// dout presents the head entry while not empty and reads as zero when empty.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; the pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; it holds data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_byte_asm.sv
// UART receive byte assembler.
// The block samples rxd whenever the bit-timing index changes, builds a byte LSB first,
// checks the stop bit, and hands completed bytes to a receive buffer.
// Define UART_RX_FIFO_EN to use a FIFO_DEPTH-entry FIFO.
// Without that macro, the buffer is a single holding register.
module uart_rx_byte_asm #(
    parameter int DATA_BITS  = uart_rx_pkg::DATA_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic [3:0]           bit_idx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 frame_err,
    output logic                 overrun
);

    import uart_rx_pkg::*;

    localparam int IDXW = $clog2(DATA_BITS);

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic                   push;
    logic                   ferr_d;
    logic                   ovr_d;
    logic [IDXW-1:0]        wpos;

    // Reject an illegal depth at elaboration so a bad build cannot slip through quietly.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_rx_byte_asm: FIFO_DEPTH must be a power of two >= 2");
    end

    // A data index k lands in shift bit k-1.
    assign wpos = IDXW'(bit_idx - 4'd1);

    // Next-state logic: act only when the timing index changes, sampling rxd in that cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        if (bit_idx != idx_q) begin
            case (state_q)
                IDLE: begin
                    if (bit_idx == 4'd1) begin
                        shift_d[0] = rxd;
                        state_d    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx_q != IDX_LAST && bit_idx == idx_q + 4'd1) begin
                        shift_d[wpos] = rxd;
                    end else begin
                        // The stop bit or an aborted frame both end the frame.
                        state_d = IDLE;
                        if (idx_q == IDX_LAST && bit_idx == IDX_IDLE) begin
                            push   = rxd;
                            ferr_d = !rxd;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, index history, shift register and frame error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= IDX_IDLE;
            shift_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= bit_idx;
            shift_q   <= shift_d;
            frame_err <= ferr_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;
    logic fifo_full;

    // In the stop-bit cycle, shift_q already holds the complete byte.
    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (shift_q),
        .dout  (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rd_valid = !fifo_empty;
    assign ovr_d    = push && fifo_full && !rd_en;
`else
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_vld_q;

    // Single-entry buffer; a same-cycle read frees the slot for the incoming byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (push && (!hold_vld_q || rd_en)) begin
            hold_q     <= shift_q;
            hold_vld_q <= 1'b1;
        end else if (rd_en) begin
            hold_vld_q <= 1'b0;
        end
    end

    assign rd_valid = hold_vld_q;
    assign rd_data  = hold_vld_q ? hold_q : '0;
    assign ovr_d    = push && hold_vld_q && !rd_en;
`endif

    // Overrun pulse, registered to line up with the buffer outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else begin
            overrun <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_byte_asm.sv
// Testbench for uart_rx_byte_asm.
// It follows UART_RX_FIFO_EN in the same way as the design.
`timescale 1ns/1ps
module tb_uart_rx_byte_asm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic [3:0] bit_idx = 4'd0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int ovr_seen = 0;

`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    always #5 clk = ~clk;

    uart_rx_byte_asm #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .bit_idx   (bit_idx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame tracker plus a byte queue with capacity CAP.
    int         m_prev = 0;
    int         m_pos = 0;
    logic [7:0] m_bits = 8'h00;
    logic [7:0] q[$];
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;
    logic       started = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            started  = 1'b1;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            if (reset) begin
                m_prev = 0;
                m_pos  = 0;
                q.delete();
            end else begin
                logic got;
                got = 1'b0;
                if (int'(bit_idx) != m_prev) begin
                    if (m_pos == 0) begin
                        if (bit_idx == 4'd1) begin
                            m_bits    = 8'h00;
                            m_bits[0] = rxd;
                            m_pos     = 1;
                        end
                    end else if (m_pos < 8 && int'(bit_idx) == m_pos + 1) begin
                        m_bits[m_pos] = rxd;
                        m_pos++;
                    end else if (m_pos == 8 && bit_idx == 4'd0) begin
                        got      = rxd;
                        exp_ferr = !rxd;
                        m_pos    = 0;
                    end else begin
                        exp_ferr = 1'b1;
                        m_pos    = 0;
                    end
                end
                m_prev = int'(bit_idx);
                if (rd_en && q.size() > 0) void'(q.pop_front());
                if (got) begin
                    if (q.size() < CAP) q.push_back(m_bits);
                    else exp_ovr = 1'b1;
                end
            end
        end
    end

    // Compare the DUT outputs with the model once per cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("rd_valid", {31'd0, rd_valid}, {31'd0, q.size() > 0});
                chk("rd_data", {24'd0, rd_data}, {24'd0, (q.size() > 0) ? q[0] : 8'h00});
                chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
                chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
                if (overrun) ovr_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Hold each index for two cycles, with rxd inverted in the second cycle
    // so that only the sample taken at the index change counts.
    task automatic send_idx(input int k, input logic b);
        bit_idx = 4'(k);
        rxd     = b;
        tick();
        rxd = ~b;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop);
        for (int k = 1; k <= 8; k++) send_idx(k, b[k-1]);
        bit_idx = 4'd0;
        rxd     = stop;
        rd_en   = pop_at_stop;
        tick();
        rd_en = 1'b0;
        rxd   = ~stop;
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        chk("pop_head", {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        tick();

        // A good 0xA5 frame arrives one cycle after its stop event.
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_valid", {31'd0, rd_valid}, 32'd1);
        chk("a5_data", {24'd0, rd_data}, 32'hA5);
        chk("a5_no_ferr", {31'd0, frame_err}, 32'd0);
        tick();
        pop_chk(8'hA5);
        chk("a5_drained", {31'd0, rd_valid}, 32'd0);

        // A bad stop bit gives one frame_err pulse and no byte.
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("badstop_ferr", {31'd0, frame_err}, 32'd1);
        chk("badstop_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        chk("badstop_ferr_pulse", {31'd0, frame_err}, 32'd0);

        // The sequence 1,2,3,0 aborts the frame; the next frame is still received.
        send_idx(1, 1'b1);
        send_idx(2, 1'b0);
        send_idx(3, 1'b1);
        bit_idx = 4'd0;
        rxd     = 1'b1;
        tick();
        chk("abort_ferr", {31'd0, frame_err}, 32'd1);
        chk("abort_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("3c_data", {24'd0, rd_data}, 32'h3C);
        tick();
        pop_chk(8'h3C);

        // Send five frames with no reads: the buffer fills and then overruns.
        ovr_seen = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        tick();
        chk("overrun_count", ovr_seen, (CAP == 4) ? 32'd1 : 32'd4);
        for (int i = 0; i < CAP; i++) pop_chk(8'(i + 1));
        chk("five_drained", {31'd0, rd_valid}, 32'd0);

        // When the buffer is full, a stop event and a read in the same cycle are both accepted.
        for (int i = 0; i < CAP; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
        tick();
        send_frame(8'h20, 1'b1, 1'b1);
        chk("fullpop_no_ovr", {31'd0, overrun}, 32'd0);
        chk("fullpop_valid", {31'd0, rd_valid}, 32'd1);
        chk("fullpop_head", {24'd0, rd_data}, (CAP == 4) ? 32'h11 : 32'h20);
        tick();
        for (int i = 1; i < CAP; i++) pop_chk(8'h10 + 8'(i));
        pop_chk(8'h20);
        chk("fullpop_drained", {31'd0, rd_valid}, 32'd0);

        // Reset at index 5 clears everything and produces no frame_err.
        send_frame(8'h77, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 5; k++) send_idx(k, k[0]);
        reset = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
        chk("midrst_data", {24'd0, rd_data}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
        chk("midrst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        send_idx(6, 1'b1);
        send_idx(7, 1'b1);
        send_idx(8, 1'b1);
        bit_idx = 4'd0;
        rxd     = 1'b1;
        tick();
        chk("midrst_tail_ferr", {31'd0, frame_err}, 32'd0);
        chk("midrst_tail_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        send_frame(8'hFF, 1'b1, 1'b0);
        chk("ff_valid", {31'd0, rd_valid}, 32'd1);
        chk("ff_data", {24'd0, rd_data}, 32'hFF);
        tick();
        pop_chk(8'hFF);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_asm.md
UART_RX_BYTE_ASM -- requirements
Module: uart_rx_byte_asm

Interface
REQ-001 Parameter DATA_BITS, 8, number of data bits per frame, LSB first.
REQ-002 Parameter FIFO_DEPTH, 4, receive buffer depth in bytes; power of two, used only with UART_RX_FIFO_EN.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rxd  input  1  UART line, already synchronised to clk.
REQ-006 bit_idx  input  4  index from the bit-timing stage: 0 = idle; k in 1..8 = midpoint of data bit k-1 reached.
REQ-007 rd_en  input  1  consumer pops the head byte when rd_en and rd_valid are both 1.
REQ-008 rd_data  output  8  head byte; valid only while rd_valid = 1.
REQ-009 rd_valid  output  1  at least one received byte is available.
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit or an index-sequence violation.
REQ-011 overrun  output  1  one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-012 The block registers bit_idx into idx_q every cycle; an event occurs in any cycle where bit_idx != idx_q, and rxd is sampled in that same cycle.
REQ-013 FSM states: IDLE, SHIFT.
- IDLE: an event with bit_idx = 1 stores rxd in shift bit 0 and moves to SHIFT.
- IDLE: events with other values are ignored.
REQ-014 SHIFT: an event with bit_idx = idx_q+1 (2..8) stores rxd in shift bit bit_idx-1.
REQ-015 SHIFT, idx_q = 8, event to bit_idx = 0 (stop-bit midpoint), then return to IDLE:
- rxd = 1: push the shift register.
- rxd = 0: pulse frame_err; no push.
REQ-016 SHIFT, any other event (skip, backward step, or 0 before 8) aborts the frame: frame_err pulses, no push, FSM returns to IDLE.
REQ-017 A pushed byte appears on rd_data with rd_valid = 1 in the cycle after the stop-bit event.
REQ-018 rd_en while rd_valid = 0 is ignored.

Reset
REQ-019 While reset = 1, on each clock: FSM goes to IDLE, idx_q = 0, shift register = 0, buffer emptied.
REQ-020 While reset = 1: rd_data = 0, rd_valid = 0, frame_err = 0, overrun = 0.
REQ-021 Reset asserted mid-frame discards the partial byte without a frame_err pulse.

Configuration
REQ-022 With macro UART_RX_FIFO_EN defined, the buffer is a FIFO_DEPTH-entry show-ahead FIFO.
- Push when full without a pop in the same cycle drops the new byte and pulses overrun.
- Push and pop in the same cycle while full are both accepted; the count is unchanged.
REQ-023 Without UART_RX_FIFO_EN, the buffer is a single holding register.
- Push while rd_valid = 1 and rd_en = 0 keeps the old byte and pulses overrun.
- Push with rd_en = 1 in the same cycle loads the new byte and rd_valid stays 1.

Structure
REQ-024 Shared package uart_rx_pkg holds DATA_BITS, IDX_IDLE = 0, IDX_LAST = 8 and the FSM state type.
REQ-025 The FIFO is sub-module uart_rx_fifo (push, pop, din, dout, empty, full); it is instantiated only under UART_RX_FIFO_EN.

Verification
REQ-026 Frame 0xA5 (bit_idx 1..8 with rxd = 1,0,1,0,0,1,0,1), then 8->0 with rxd = 1 -> rd_valid = 1 and rd_data = 0xA5 exactly one cycle after the stop event; frame_err = 0.
REQ-027 Same frame with rxd = 0 at the 8->0 event -> one frame_err pulse; rd_valid stays 0.
REQ-028 bit_idx sequence 1,2,3,0 -> frame_err pulses on the 3->0 event; no push; the next valid frame 0x3C is received correctly.
REQ-029 Five good frames 0x01..0x05 with no reads:
- FIFO_EN: bytes 0x01..0x04 are stored and overrun pulses once on 0x05; four pops return 0x01..0x04 in order.
- Without the macro: 0x01 is held and overrun pulses four times.
REQ-030 Buffer full, stop event coincident with rd_en = 1 -> head is popped, new byte accepted, no overrun.
REQ-031 Reset asserted at bit_idx = 5 -> all outputs 0 the next cycle; no byte and no frame_err; the following frame 0xFF is received correctly.
